// File: rtl/serial_subtractor_with_enable_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor_with_enable_if
//  Brief    : Operand/result bundle for the bit-serial subtractor.
//             The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
//  Revision : 1.0
// ============================================================================
interface serial_subtractor_with_enable_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (
    output enable, start, a, b,
    input  busy, done, diff, bout, ovf
  );
  modport slave (
    input  enable, start, a, b,
    output busy, done, diff, bout, ovf
  );
`else
  modport master (
    output enable, start, a, b,
    input  busy, done, diff, bout
  );
  modport slave (
    input  enable, start, a, b,
    output busy, done, diff, bout
  );
`endif
endinterface
`default_nettype wire

// File: rtl/serial_subtractor_with_enable.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor_with_enable
//  Brief    : Bit-serial a - b, LSB first, one bit per enabled clock.
//             Optional macro SERIAL_SUB_OVF_EN adds signed-overflow output.
//  Revision : 1.0
// ============================================================================
module serial_subtractor_with_enable #(
  parameter int WIDTH = 8
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  serial_subtractor_with_enable_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             bit_d;
  logic             bit_br;
  logic [WIDTH-1:0] res_next;

`ifdef SERIAL_SUB_OVF_EN
  logic am_q, am_d;
  logic bm_q, bm_d;
  logic ovf_q, ovf_d;
`endif

  // One full-subtractor slice on the current operand LSBs.
  assign bit_d    = a_q[0] ^ b_q[0] ^ br_q;
  assign bit_br   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign res_next = {bit_d, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    am_d    = am_q;
    bm_d    = bm_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_SHIFT: begin
        if (bus.enable) begin
          res_d = res_next;
          br_d  = bit_br;
          a_d   = a_q >> 1;
          b_d   = b_q >> 1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            diff_d  = res_next;
            bout_d  = bit_br;
`ifdef SERIAL_SUB_OVF_EN
            ovf_d   = (am_q ^ bm_q) & (am_q ^ bit_d);
`endif
          end
        end
      end
      default: begin
        // IDLE and DONE both accept a new operation; DONE never lingers.
        if (bus.enable && bus.start) begin
          state_d = ST_SHIFT;
          busy_d  = 1'b1;
          a_d     = bus.a;
          b_d     = bus.b;
          br_d    = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
          am_d    = bus.a[WIDTH-1];
          bm_d    = bus.b[WIDTH-1];
`endif
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      am_q    <= 1'b0;
      bm_q    <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      am_q    <= am_d;
      bm_q    <= bm_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor_with_enable.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_subtractor_with_enable
//  Brief    : Directed self-checking bench for the bit-serial subtractor.
//  Revision : 1.0
// ============================================================================
module tb_serial_subtractor_with_enable;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   n;
  int   pulses;

  serial_subtractor_with_enable_if #(.WIDTH(8)) sif ();

  serial_subtractor_with_enable #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ticks until done is seen, bounded; returns ticks taken.
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (sif.done !== 1'b1 && cnt < 50) begin
      tick();
      cnt++;
    end
  endtask

  task automatic launch(input logic [7:0] av, input logic [7:0] bv);
    sif.a     = av;
    sif.b     = bv;
    sif.start = 1'b1;
    sif.enable = 1'b1;
    tick();
    sif.start = 1'b0;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    sif.enable = 1'b0;
    sif.start  = 1'b0;
    sif.a      = '0;
    sif.b      = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_busy", 32'(sif.busy), 32'd0);
    check("reset_done", 32'(sif.done), 32'd0);
    check("reset_diff", 32'(sif.diff), 32'd0);
    check("reset_bout", 32'(sif.bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset_ovf", 32'(sif.ovf), 32'd0);
`endif

    // start with enable low is ignored
    sif.a = 8'd10; sif.b = 8'd3; sif.start = 1'b1; sif.enable = 1'b0;
    tick();
    sif.start = 1'b0;
    check("gated_start_busy", 32'(sif.busy), 32'd0);

    // 10 - 3
    launch(8'd10, 8'd3);
    check("t1_busy", 32'(sif.busy), 32'd1);
    wait_done(n);
    check("t1_latency", 32'(n), 32'd8);
    check("t1_diff", 32'(sif.diff), 32'd7);
    check("t1_bout", 32'(sif.bout), 32'd0);
    check("t1_busy_done", 32'(sif.busy), 32'd0);
    tick();
    check("t1_done_pulse", 32'(sif.done), 32'd0);

    // 3 - 10 wraps; diff holds previous value until completion
    launch(8'd3, 8'd10);
    check("t2_diff_held", 32'(sif.diff), 32'd7);
    wait_done(n);
    check("t2_latency", 32'(n), 32'd8);
    check("t2_diff", 32'(sif.diff), 32'hF9);
    check("t2_bout", 32'(sif.bout), 32'd1);
    tick();

    launch(8'hA5, 8'hA5);
    wait_done(n);
    check("t2_eq_diff", 32'(sif.diff), 32'd0);
    check("t2_eq_bout", 32'(sif.bout), 32'd0);
    tick();

    // enable low for 3 cycles after 2 shifted bits
    launch(8'd3, 8'd10);
    tick();
    tick();
    sif.enable = 1'b0;
    tick(); tick(); tick();
    check("t3_gated_busy", 32'(sif.busy), 32'd1);
    check("t3_gated_done", 32'(sif.done), 32'd0);
    sif.enable = 1'b1;
    wait_done(n);
    check("t3_remaining", 32'(n), 32'd6);
    check("t3_diff", 32'(sif.diff), 32'hF9);
    check("t3_bout", 32'(sif.bout), 32'd1);

    // start while busy ignored; back-to-back start in the DONE cycle
    tick();
    launch(8'd10, 8'd3);
    tick();
    tick();
    sif.a = 8'd200; sif.b = 8'd1; sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    wait_done(n);
    check("t4_remaining", 32'(n), 32'd5);
    check("t4_diff", 32'(sif.diff), 32'd7);
    check("t4_bout", 32'(sif.bout), 32'd0);
    launch(8'h80, 8'h01);
    check("t4_restart_busy", 32'(sif.busy), 32'd1);
    check("t4_restart_done", 32'(sif.done), 32'd0);
    wait_done(n);
    check("t4b_latency", 32'(n), 32'd8);
    check("t4b_diff", 32'(sif.diff), 32'h7F);
    check("t4b_bout", 32'(sif.bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("t6_ovf_set", 32'(sif.ovf), 32'd1);
`endif
    tick();

    launch(8'h05, 8'h03);
    wait_done(n);
    check("t6_diff", 32'(sif.diff), 32'h02);
`ifdef SERIAL_SUB_OVF_EN
    check("t6_ovf_clear", 32'(sif.ovf), 32'd0);
`endif
    tick();

    // reset after 4 shifted bits aborts without a done pulse
    launch(8'd10, 8'd3);
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", 32'(sif.busy), 32'd0);
    check("t5_done", 32'(sif.done), 32'd0);
    check("t5_diff", 32'(sif.diff), 32'd0);
    check("t5_bout", 32'(sif.bout), 32'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sif.done === 1'b1) pulses++;
    end
    check("t5_no_done", 32'(pulses), 32'd0);
    launch(8'h00, 8'h01);
    wait_done(n);
    check("t5_latency", 32'(n), 32'd8);
    check("t5_diff", 32'(sif.diff), 32'hFF);
    check("t5_bout", 32'(sif.bout), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
